// File: rtl/convert_array_pkg.sv
// Shared types and index-map helpers for the sub-row array flatten/unflatten stream blocks.
package convert_array_pkg;

  typedef enum logic [0:0] {ASSEMBLE, HOLD} state_t;

  // Flat k -> row: first region is column-major over sub_rows rows, the rest over rows-sub_rows.
  function automatic int unsigned flat_to_row(input int unsigned k, input int unsigned rows,
                                              input int unsigned cols, input int unsigned sub_rows);
    if (k < cols * sub_rows) return k % sub_rows;
    return sub_rows + (k - cols * sub_rows) % (rows - sub_rows);
  endfunction

  function automatic int unsigned flat_to_col(input int unsigned k, input int unsigned rows,
                                              input int unsigned cols, input int unsigned sub_rows);
    if (k < cols * sub_rows) return k / sub_rows;
    return (k - cols * sub_rows) / (rows - sub_rows);
  endfunction

  function automatic int unsigned rc_to_flat(input int unsigned r, input int unsigned c,
                                             input int unsigned rows, input int unsigned cols,
                                             input int unsigned sub_rows);
    if (r < sub_rows) return c * sub_rows + r;
    return cols * sub_rows + c * (rows - sub_rows) + (r - sub_rows);
  endfunction

endpackage

// File: rtl/sub_array_lane_writer.sv
// Per-lane write-enable decoder: constant (beat, lane) -> (row, col) table selected by beat_cnt.
module sub_array_lane_writer
  import convert_array_pkg::*;
#(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned SUB_ROWS = 4,
  parameter int unsigned LANES    = 4,
  parameter int unsigned LANE     = 0,
  parameter int unsigned CNT_W    = 4
) (
  input  logic [CNT_W-1:0]     beat_cnt,
  input  logic                 wr,
  output logic [ROWS*COLS-1:0] wen
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int unsigned K = rc_to_flat(r, c, ROWS, COLS, SUB_ROWS);
      if (K % LANES == LANE) begin : g_own
        assign wen[r*COLS+c] = wr && (beat_cnt == CNT_W'(K / LANES));
      end else begin : g_other
        assign wen[r*COLS+c] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/convert_1d_to_3d_sub_array_stream.sv
// Rebuilds a ROWS x COLS frame from a flat sub-row-ordered lane stream.
// Optional framing check (in_last / frame_err) enabled by `define FRAME_CHECK_EN.
module convert_1d_to_3d_sub_array_stream
  import convert_array_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned SUB_ROWS  = 4,
  parameter int unsigned LANES     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LANES*BIT_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [BIT_WIDTH-1:0]       out [ROWS][COLS],
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef FRAME_CHECK_EN
  ,
  input  logic                       in_last,
  output logic                       frame_err
`endif
);

  localparam int unsigned BEATS = ROWS * COLS / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (ROWS * COLS % LANES != 0) begin : g_bad_lanes
    $fatal(1, "ROWS*COLS must be a multiple of LANES");
  end
  if (SUB_ROWS > ROWS) begin : g_bad_sub_rows
    $fatal(1, "SUB_ROWS must not exceed ROWS");
  end

  state_t                       state;
  logic [CNT_W-1:0]             beat_cnt;
  logic [BIT_WIDTH-1:0]         asm_buf    [ROWS][COLS];
  logic [BIT_WIDTH-1:0]         next_frame [ROWS][COLS];
  logic [LANES-1:0][ROWS*COLS-1:0] lane_wen;
  logic accept, last_beat, slot_free, abort, write_beat;

  assign in_ready   = (state == ASSEMBLE);
  assign accept     = in_valid && in_ready;
  assign last_beat  = (beat_cnt == CNT_W'(BEATS - 1));
  assign slot_free  = !out_valid || out_ready;
  assign write_beat = accept && !abort;

`ifdef FRAME_CHECK_EN
  assign abort = accept && in_last && !last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= accept && (in_last != last_beat);
  end
`else
  assign abort = 1'b0;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sub_array_lane_writer #(
      .ROWS(ROWS), .COLS(COLS), .SUB_ROWS(SUB_ROWS),
      .LANES(LANES), .LANE(l), .CNT_W(CNT_W)
    ) u_lane (
      .beat_cnt(beat_cnt),
      .wr(write_beat),
      .wen(lane_wen[l])
    );
  end

  // Each cell has exactly one source lane, so the data mux is a constant wire per cell.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int unsigned SRC = rc_to_flat(r, c, ROWS, COLS, SUB_ROWS) % LANES;
      logic [LANES-1:0] hits;
      for (genvar l = 0; l < LANES; l++) begin : g_hit
        assign hits[l] = lane_wen[l][r*COLS+c];
      end
      assign next_frame[r][c] = (|hits) ? in_data[SRC*BIT_WIDTH +: BIT_WIDTH] : asm_buf[r][c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ASSEMBLE;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          out[r][c]     <= '0;
          asm_buf[r][c] <= '0;
        end
      end
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state)
        ASSEMBLE: begin
          if (accept) begin
            if (abort) begin
              beat_cnt <= '0;
              for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) asm_buf[r][c] <= '0;
              end
            end else begin
              asm_buf <= next_frame;
              if (last_beat) begin
                beat_cnt <= '0;
                if (slot_free) begin
                  out       <= next_frame;
                  out_valid <= 1'b1;
                end else begin
                  state <= HOLD;
                end
              end else begin
                beat_cnt <= beat_cnt + CNT_W'(1);
              end
            end
          end
        end
        HOLD: begin
          // out_valid is necessarily high here; the held frame replaces it on hand-off.
          if (out_ready) begin
            out       <= asm_buf;
            out_valid <= 1'b1;
            state     <= ASSEMBLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_convert_1d_to_3d_sub_array_stream.sv
// Directed bench for convert_1d_to_3d_sub_array_stream; FRAME_CHECK_EN adds framing-error steps.
module tb_convert_1d_to_3d_sub_array_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  out_d [8][8];

  logic [3:0]  in_data1;
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [3:0]  out1 [8][8];

`ifdef FRAME_CHECK_EN
  logic in_last, frame_err, in_last1, frame_err1;
`endif

  int errors = 0;
  int checks = 0;

  convert_1d_to_3d_sub_array_stream #(
    .BIT_WIDTH(4), .ROWS(8), .COLS(8), .SUB_ROWS(4), .LANES(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out(out_d), .out_valid(out_valid), .out_ready(out_ready)
`ifdef FRAME_CHECK_EN
    , .in_last(in_last), .frame_err(frame_err)
`endif
  );

  convert_1d_to_3d_sub_array_stream #(
    .BIT_WIDTH(4), .ROWS(8), .COLS(8), .SUB_ROWS(0), .LANES(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out(out1), .out_valid(out_valid1), .out_ready(out_ready1)
`ifdef FRAME_CHECK_EN
    , .in_last(in_last1), .frame_err(frame_err1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Element k of frame f carries (k+f) mod 16.
  function automatic logic [15:0] beat_word(input int unsigned b, input int unsigned f);
    logic [15:0] w;
    for (int unsigned l = 0; l < 4; l++) w[l*4 +: 4] = 4'((b*4 + l + f) & 15);
    return w;
  endfunction

  // Forward index map: flat k -> (row, col), compared against the default-config output.
  function automatic int unsigned frame_mism(input int unsigned f);
    int unsigned m, r, c, kk;
    m = 0;
    for (int unsigned k = 0; k < 64; k++) begin
      if (k < 32) begin
        r = k % 4; c = k / 4;
      end else begin
        kk = k - 32; r = 4 + kk % 4; c = kk / 4;
      end
      if (out_d[r][c] !== 4'((k + f) & 15)) m++;
    end
    return m;
  endfunction

  function automatic int unsigned zero_mism();
    int unsigned m;
    m = 0;
    for (int unsigned r = 0; r < 8; r++)
      for (int unsigned c = 0; c < 8; c++)
        if (out_d[r][c] !== 4'd0) m++;
    return m;
  endfunction

  task automatic drive_beat(input int unsigned b, input int unsigned f);
    in_data = beat_word(b, f);
`ifdef FRAME_CHECK_EN
    in_last = (b == 15);
`endif
  endtask

  task automatic send_frame(input int unsigned f);
    in_valid = 1'b1;
    for (int unsigned b = 0; b < 16; b++) begin
      drive_beat(b, f);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int unsigned g, rx, mism, cyc, m1;
    logic iv, orr;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
`ifdef FRAME_CHECK_EN
    in_last = 1'b0; in_last1 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_zero", zero_mism(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single frame with ready downstream, then latency and spot values
    out_ready = 1'b1; in_valid = 1'b1;
    for (int unsigned b = 0; b < 16; b++) begin
      drive_beat(b, 0);
      if (b == 15) chk("t1_no_early_valid", out_valid, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_r1c0", out_d[1][0], 4'd1);
    chk("t1_r0c1", out_d[0][1], 4'd4);
    chk("t1_r3c7", out_d[3][7], 4'd15);
    chk("t1_r4c0", out_d[4][0], 4'd0);
    chk("t1_r5c0", out_d[5][0], 4'd1);
    chk("t1_r7c7", out_d[7][7], 4'd15);
    chk("t1_frame", frame_mism(0), 0);
    @(negedge clk);
    chk("t1_valid_clears", out_valid, 0);

    // back-to-back frames, no bubble on the input
    in_valid = 1'b1;
    for (int unsigned f = 1; f <= 2; f++) begin
      for (int unsigned b = 0; b < 16; b++) begin
        drive_beat(b, f);
        if (f == 2 && b == 0) begin
          chk("b2b_valid1", out_valid, 1);
          chk("b2b_frame1", frame_mism(1), 0);
          chk("b2b_in_ready", in_ready, 1);
        end
        if (f == 2 && b == 1) chk("b2b_consumed", out_valid, 0);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    chk("b2b_valid2", out_valid, 1);
    chk("b2b_frame2", frame_mism(2), 0);
    @(negedge clk);
    chk("b2b_clears", out_valid, 0);

    // 2: second frame completes while the slot is occupied -> HOLD
    out_ready = 1'b0;
    send_frame(3);
    send_frame(4);
    chk("t2_hold_in_ready", in_ready, 0);
    chk("t2_hold_valid", out_valid, 1);
    chk("t2_hold_frame3", frame_mism(3), 0);
    @(negedge clk);
    chk("t2_hold_stays", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t2_release_in_ready", in_ready, 1);
    chk("t2_release_valid", out_valid, 1);
    chk("t2_release_frame4", frame_mism(4), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t2_drained", out_valid, 0);

    // 3: random stalls on both sides, 100 frames
    g = 0; rx = 0; mism = 0; cyc = 0;
    while (rx < 100 && cyc < 20000) begin
      iv  = (g < 1600) && ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 3) != 0);
      in_valid  = iv;
      drive_beat(g % 16, g / 16);
      out_ready = orr;
      if (out_valid && orr) begin
        if (frame_mism(rx) != 0) mism++;
        rx++;
      end
      if (iv && in_ready) g++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t3_frames_received", rx, 100);
    chk("t3_beats_sent", g, 1600);
    chk("t3_frame_mismatches", mism, 0);
    chk("t3_drained", out_valid, 0);

    // 4: async reset mid-frame with a valid frame pending
    send_frame(7);
    chk("t4_pending", out_valid, 1);
    in_valid = 1'b1;
    for (int unsigned b = 0; b < 9; b++) begin
      drive_beat(b, 8);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", out_valid, 0);
    chk("t4_rst_out_zero", zero_mism(), 0);
    chk("t4_rst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_frame(9);
    chk("t4_clean_valid", out_valid, 1);
    chk("t4_clean_frame", frame_mism(9), 0);
    @(negedge clk);
    out_ready = 1'b0;

    // 5: LANES=1, SUB_ROWS=0 -> plain column-major
    out_ready1 = 1'b1; in_valid1 = 1'b1;
    for (int unsigned k = 0; k < 64; k++) begin
      in_data1 = 4'(k & 15);
`ifdef FRAME_CHECK_EN
      in_last1 = (k == 63);
`endif
      if (k == 63) chk("t5_no_early_valid", out_valid1, 0);
      @(negedge clk);
    end
    in_valid1 = 1'b0;
    chk("t5_valid", out_valid1, 1);
    m1 = 0;
    for (int unsigned r = 0; r < 8; r++)
      for (int unsigned c = 0; c < 8; c++)
        if (out1[r][c] !== 4'((c*8 + r) & 15)) m1++;
    chk("t5_frame", m1, 0);
    chk("t5_r3c2", out1[3][2], 4'd3);
    chk("t5_r0c1", out1[0][1], 4'd8);

`ifdef FRAME_CHECK_EN
    // 6: early in_last aborts the frame; missing in_last only flags
    out_ready = 1'b1; in_valid = 1'b1;
    for (int unsigned b = 0; b <= 5; b++) begin
      in_data = beat_word(b, 10);
      in_last = (b == 5);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("t6_err_pulse", frame_err, 1);
    chk("t6_no_valid", out_valid, 0);
    @(negedge clk);
    chk("t6_err_clears", frame_err, 0);
    send_frame(11);
    chk("t6_next_valid", out_valid, 1);
    chk("t6_next_frame", frame_mism(11), 0);
    chk("t6_next_no_err", frame_err, 0);
    in_valid = 1'b1;
    for (int unsigned b = 0; b < 16; b++) begin
      in_data = beat_word(b, 12);
      in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t6_missing_last_err", frame_err, 1);
    chk("t6_missing_last_valid", out_valid, 1);
    chk("t6_missing_last_frame", frame_mism(12), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
